strobe_scheduler: RTL
=====================

// Module: strobe_scheduler
// PURPOSE
//  Multi-channel programmable strobe timebase: one shared free-running prescaler feeds NUM_CH
//  independent down-counters, each run-time configured to emit periodic or one-shot tick strobes.
//  Replaces per-consumer fixed-length clock dividers (cursor blink, keypad scan, UI timeouts);
//  consumers sample tick[i] as a clock enable on clk, never as a clock.
// PARAMETERS
//  NUM_CH    4     number of strobe channels (1..16)
//  CNT_W     16    width of per-channel period / down-counter
//  PRESCALE  100   clk cycles per base tick (>=2); base period for all channels
// PORTS
//  clk          in   1               system clock
//  rst          in   1               synchronous, active-high reset
//  cfg_valid    in   1               config command valid
//  cfg_ready    out  1               config command accepted when valid&ready
//  cfg_op       in   2               0=LOAD period, 1=START, 2=STOP, 3=reserved (error)
//  cfg_ch       in   $clog2(NUM_CH)+1  target channel
//  cfg_period   in   CNT_W           period in base ticks (LOAD only)
//  cfg_oneshot  in   1               START only: 1=one-shot, 0=periodic
//  cfg_err      out  1               1-cycle pulse: rejected command
//  busy         out  NUM_CH          channel i running
//  tick         out  NUM_CH          channel i strobe
//  tick_ack     in   NUM_CH          (STROBE_SCHED_ACK_EN only) consumer acknowledge
//  ovr          out  NUM_CH          (STROBE_SCHED_ACK_EN only) sticky overrun
// BEHAVIOUR
//  Reset: prescaler=0, all channels IDLE, periods=0, tick/busy/cfg_err/ovr=0, cfg_ready=0.
//  cfg_ready: registered; 0 in reset and first cycle after, then constant 1.
//  Prescaler: pre_cnt 0..PRESCALE-1 wraps; base_tick=(pre_cnt==PRESCALE-1); free-running, not
//   restarted by commands (start-to-first-tick jitter up to one base period is by design).
//  Channel FSM IDLE/RUN; busy[i]=(state==RUN).
//   LOAD: period[i]<=cfg_period; in RUN the running countdown is untouched, new value used at next reload.
//   START: if period[i]==0 -> cfg_err, no change; else cnt<=period[i], mode<=cfg_oneshot, ->RUN
//     (START while RUN = restart, no tick emitted).
//   STOP: ->IDLE; no-op if IDLE.
//   RUN on base_tick: cnt==1 -> fire; periodic: cnt<=period[i]; one-shot: ->IDLE. Else cnt<=cnt-1.
//  Fire latency: tick[i] high in the cycle after the base_tick that expires; first fire is the
//   period-th base_tick after START. One-shot: busy falls same cycle tick rises.
//  Simultaneous command and expiry on same channel: command wins (STOP suppresses tick; START restarts).
//  cfg_err pulse (next cycle) for: cfg_ch>=NUM_CH, cfg_op==3, START with period 0. Rejected commands
//   change no state. Commands only act on valid&ready.
// CONFIGURATION
//  STROBE_SCHED_ACK_EN undefined: tick[i] is a 1-cycle pulse; tick_ack/ovr ports absent.
//  STROBE_SCHED_ACK_EN defined: tick[i] is set on fire, held until tick_ack[i] (clears next cycle);
//   fire while tick[i] still held sets ovr[i] (sticky); ack and fire same cycle -> tick stays 1, no ovr.
//   ovr[i] cleared by reset or accepted STOP on channel i. STOP does not clear a pending tick.
// STRUCTURE
//  strobe_sched_pkg: cfg_op encodings (OP_LOAD/OP_START/OP_STOP), channel state enum.
//  Sub-module strobe_sched_channel: one channel FSM + counter + period reg, generate-instantiated
//   NUM_CH times; top holds prescaler, command decode/error check, cfg_ready.
// TESTING (NUM_CH=2, CNT_W=8, PRESCALE=4)
//  Reset 3 cycles -> tick=busy=cfg_err=0; cfg_ready=0 until 2nd cycle after rst falls, then 1.
//  LOAD ch0=3, START periodic -> tick[0] 1-cycle pulses exactly every 12 clk, busy[0]=1 throughout.
//  LOAD ch1=2, START one-shot -> single tick[1] within 5..8 clk, busy[1] falls that cycle, no more ticks.
//  START ch0 with period 0; any op with cfg_ch=3 -> cfg_err 1-cycle pulse each, busy unchanged.
//  STOP ch0 issued in the expiring base_tick cycle -> no tick, busy[0]=0 next cycle.
//  ACK_EN: no ack across 2 expirations -> tick[0] held, ovr[0]=1; ack -> tick 0; STOP -> ovr 0.

Source files
------------

// File: rtl/strobe_sched_pkg.sv
// Shared encodings for the strobe scheduler: command opcodes and channel state.
package strobe_sched_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_START = 2'd1,
    OP_STOP  = 2'd2,
    OP_RSVD  = 2'd3
  } cfg_op_e;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/strobe_sched_if.sv
// Config/strobe bundle of the strobe scheduler.
// STROBE_SCHED_ACK_EN adds the tick_ack/ovr pair.
interface strobe_sched_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int CH_W = $clog2(NUM_CH) + 1;

  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_op;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_period;
  logic              cfg_oneshot;
  logic              cfg_err;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] tick;
`ifdef STROBE_SCHED_ACK_EN
  logic [NUM_CH-1:0] tick_ack;
  logic [NUM_CH-1:0] ovr;
`endif

  modport master (
`ifdef STROBE_SCHED_ACK_EN
    output tick_ack,
    input  ovr,
`endif
    output cfg_valid, cfg_op, cfg_ch, cfg_period, cfg_oneshot,
    input  cfg_ready, cfg_err, busy, tick
  );

  modport slave (
`ifdef STROBE_SCHED_ACK_EN
    input  tick_ack,
    output ovr,
`endif
    input  cfg_valid, cfg_op, cfg_ch, cfg_period, cfg_oneshot,
    output cfg_ready, cfg_err, busy, tick
  );
endinterface

// File: rtl/strobe_sched_channel.sv
// One strobe channel: period register, down-counter and IDLE/RUN FSM.
// STROBE_SCHED_ACK_EN makes tick sticky until acknowledged and adds overrun.
module strobe_sched_channel
  import strobe_sched_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             base_tick,
  input  logic             load,
  input  logic             start,
  input  logic             stop,
  input  logic             oneshot,
  input  logic [CNT_W-1:0] period_in,
`ifdef STROBE_SCHED_ACK_EN
  input  logic             tick_ack,
  output logic             ovr,
`endif
  output logic             period_zero,
  output logic             busy,
  output logic             tick
);
  ch_state_e        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] period_reg, period_next;
  logic             mode_reg, mode_next;
  logic             tick_reg, tick_next;
  logic             fire;
`ifdef STROBE_SCHED_ACK_EN
  logic             ovr_reg, ovr_next;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= CH_IDLE;
      cnt_reg    <= '0;
      period_reg <= '0;
      mode_reg   <= 1'b0;
      tick_reg   <= 1'b0;
`ifdef STROBE_SCHED_ACK_EN
      ovr_reg    <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      period_reg <= period_next;
      mode_reg   <= mode_next;
      tick_reg   <= tick_next;
`ifdef STROBE_SCHED_ACK_EN
      ovr_reg    <= ovr_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    mode_next   = mode_reg;
    fire        = 1'b0;
    period_next = load ? period_in : period_reg;
    // A command in the same cycle as an expiry takes precedence over the fire.
    if (stop) begin
      state_next = CH_IDLE;
    end else if (start) begin
      cnt_next   = period_reg;
      mode_next  = oneshot;
      state_next = CH_RUN;
    end else if (state_reg == CH_RUN && base_tick) begin
      if (cnt_reg == CNT_W'(1)) begin
        fire = 1'b1;
        if (mode_reg) state_next = CH_IDLE;
        else          cnt_next   = period_reg;
      end else begin
        cnt_next = cnt_reg - 1'b1;
      end
    end
`ifdef STROBE_SCHED_ACK_EN
    tick_next = fire | (tick_reg & ~tick_ack);
    ovr_next  = stop ? 1'b0 : (ovr_reg | (fire & tick_reg & ~tick_ack));
`else
    tick_next = fire;
`endif
  end

  assign period_zero = (period_reg == '0);
  assign busy        = (state_reg == CH_RUN);
  assign tick        = tick_reg;
`ifdef STROBE_SCHED_ACK_EN
  assign ovr         = ovr_reg;
`endif
endmodule

// File: rtl/strobe_scheduler.sv
// Multi-channel strobe timebase: shared prescaler, command decode, NUM_CH channels.
// STROBE_SCHED_ACK_EN selects acknowledged ticks with overrun flags.
module strobe_scheduler
  import strobe_sched_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_W    = 16,
  parameter int PRESCALE = 100
) (
  input  logic          clk,
  input  logic          rst,
  strobe_sched_if.slave bus
);
  localparam int CH_W  = $clog2(NUM_CH) + 1;
  localparam int PRE_W = $clog2(PRESCALE);

  logic [PRE_W-1:0]  pre_cnt_reg, pre_cnt_next;
  logic              base_tick;
  logic              rdy_arm_reg, cfg_ready_reg, cfg_err_reg;
  logic              accept, range_bad, start_bad, cmd_bad;
  cfg_op_e           op;
  logic [NUM_CH-1:0] ch_hit, period_zero, load_en, start_en, stop_en;
  logic [NUM_CH-1:0] busy_w, tick_w;
`ifdef STROBE_SCHED_ACK_EN
  logic [NUM_CH-1:0] ovr_w;
`endif

  assign op           = cfg_op_e'(bus.cfg_op);
  assign base_tick    = (pre_cnt_reg == PRE_W'(PRESCALE - 1));
  assign pre_cnt_next = base_tick ? '0 : pre_cnt_reg + 1'b1;
  assign accept       = bus.cfg_valid && cfg_ready_reg;
  assign range_bad    = (bus.cfg_ch >= CH_W'(NUM_CH));
  assign start_bad    = (op == OP_START) && |(ch_hit & period_zero);
  assign cmd_bad      = range_bad || (op == OP_RSVD) || start_bad;

  // Ready comes up two cycles after reset so no command races the reset release.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_reg   <= '0;
      rdy_arm_reg   <= 1'b0;
      cfg_ready_reg <= 1'b0;
      cfg_err_reg   <= 1'b0;
    end else begin
      pre_cnt_reg   <= pre_cnt_next;
      rdy_arm_reg   <= 1'b1;
      cfg_ready_reg <= rdy_arm_reg;
      cfg_err_reg   <= accept && cmd_bad;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign ch_hit[gi]   = accept && (bus.cfg_ch == CH_W'(gi));
    assign load_en[gi]  = ch_hit[gi] && !cmd_bad && (op == OP_LOAD);
    assign start_en[gi] = ch_hit[gi] && !cmd_bad && (op == OP_START);
    assign stop_en[gi]  = ch_hit[gi] && !cmd_bad && (op == OP_STOP);

    strobe_sched_channel #(.CNT_W(CNT_W)) u_ch (
      .clk         (clk),
      .rst         (rst),
      .base_tick   (base_tick),
      .load        (load_en[gi]),
      .start       (start_en[gi]),
      .stop        (stop_en[gi]),
      .oneshot     (bus.cfg_oneshot),
      .period_in   (bus.cfg_period),
`ifdef STROBE_SCHED_ACK_EN
      .tick_ack    (bus.tick_ack[gi]),
      .ovr         (ovr_w[gi]),
`endif
      .period_zero (period_zero[gi]),
      .busy        (busy_w[gi]),
      .tick        (tick_w[gi])
    );
  end

  assign bus.cfg_ready = cfg_ready_reg;
  assign bus.cfg_err   = cfg_err_reg;
  assign bus.busy      = busy_w;
  assign bus.tick      = tick_w;
`ifdef STROBE_SCHED_ACK_EN
  assign bus.ovr       = ovr_w;
`endif
endmodule
